// File: rtl/mdu_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  localparam logic [6:0] M_FUNCT7 = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu.sv
// Iterative RV32M unit: shift-add multiply and restoring divide, one bit per cycle.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  mdu_state_e         state_q, state_d;
  mdu_op_e            op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mc_q, mc_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   res_q, res_d;

  // Incoming operand conditioning
  mdu_op_e          fop;
  logic             in_div, in_rem, sgn_a, sgn_b, div_zero, div_ovf;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign fop      = mdu_op_e'(funct3);
  assign in_div   = funct3[2];
  assign in_rem   = funct3[1];
  assign sgn_a    = op_a[WIDTH-1] && (fop == OP_MULH || fop == OP_MULHSU ||
                                      fop == OP_DIV  || fop == OP_REM);
  assign sgn_b    = op_b[WIDTH-1] && (fop == OP_MULH || fop == OP_DIV || fop == OP_REM);
  assign mag_a    = sgn_a ? -op_a : op_a;
  assign mag_b    = sgn_b ? -op_b : op_b;
  assign div_zero = in_div && (op_b == '0);
  assign div_ovf  = (fop == OP_DIV || fop == OP_REM) && (op_b == '1) &&
                    (op_a == {1'b1, {(WIDTH-1){1'b0}}});

  // One iteration of each algorithm
  logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
  logic               rem_ge;
  logic [2*WIDTH-1:0] mul_step, div_step, prod;
  logic [WIDTH-1:0]   quo, rmd, fix_val;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mc_q} : '0);
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_ge   = rem_sh >= {1'b0, mc_q};
  assign rem_diff = rem_sh - {1'b0, mc_q};
  assign div_step = {rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0],
                     acc_q[WIDTH-2:0], rem_ge};

  assign prod = neg_q ? -acc_q : acc_q;
  assign quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rmd  = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    fix_val = '0;
    case (op_q)
      OP_MUL:                       fix_val = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fix_val = quo;
      default:                      fix_val = rmd;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mc_d    = mc_q;
    neg_d   = neg_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = fop;
          cnt_d = '0;
          if (div_zero) begin
            res_d   = in_rem ? op_a : '1;
            state_d = DONE;
          end else if (div_ovf) begin
            res_d   = in_rem ? '0 : op_a;
            state_d = DONE;
          end else if (in_div) begin
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            mc_d    = mag_b;
            neg_d   = in_rem ? sgn_a : (sgn_a ^ sgn_b);
            state_d = CALC;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, mag_b};
            mc_d    = mag_a;
            neg_d   = sgn_a ^ sgn_b;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = op_q[2] ? div_step : mul_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        res_d   = fix_val;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a result capture in FIX.
    if (flush) begin
      state_d = IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      acc_q   <= '0;
      mc_q    <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mc_q    <= mc_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = res_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: vector table plus abort/reset/re-start sequences.
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          cyc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op at cycle 0, hold start until done; check latency, result, busy span.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int cyc);
    int k;
    bit seen, bad_busy;
    @(posedge clk); #1;
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    k = 0; seen = 0; bad_busy = 0;
    while (!seen && k < 60) begin
      @(posedge clk); #1;
      k++;
      if (!busy) bad_busy = 1;
      if (done) begin
        seen = 1;
        start = 1'b0;
      end
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_done_cycle"}, 32'(k), 32'(cyc));
    chk({name, "_result"}, result, exp);
    chk({name, "_busy_span"}, 32'(bad_busy), 32'd0);
    @(posedge clk); #1;
    chk({name, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    chk({name, "_result_hold"}, result, exp);
  endtask

  vec_t vecs[18];

  initial begin
    int k, ndone;
    vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
    vecs[4]  = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 34};
    vecs[5]  = '{3'd0, 32'h00012345, 32'h00010000, 32'h23450000, 34};
    vecs[6]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    vecs[7]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
    vecs[8]  = '{3'd5, 32'd100,      32'd7,        32'd14,       34};
    vecs[9]  = '{3'd7, 32'd100,      32'd7,        32'd2,        34};
    vecs[10] = '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
    vecs[11] = '{3'd6, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 34};
    vecs[12] = '{3'd4, 32'h00001234, 32'd0,        32'hFFFFFFFF, 1};
    vecs[13] = '{3'd6, 32'h00001234, 32'd0,        32'h00001234, 1};
    vecs[14] = '{3'd5, 32'h00001234, 32'd0,        32'hFFFFFFFF, 1};
    vecs[15] = '{3'd7, 32'h00001234, 32'd0,        32'h00001234, 1};
    vecs[16] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[17] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};

    #12;
    chk("reset_outputs", {busy, done, result[29:0]}, 32'd0);
    chk("reset_result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 18; i++)
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].cyc);

    // Second request with different operands during a running DIVU is ignored.
    @(posedge clk); #1;
    funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    k = 0; ndone = 0;
    while (k < 45) begin
      @(posedge clk); #1;
      k++;
      if (k == 5) begin funct3 = 3'd5; op_a = 32'd999; op_b = 32'd3; end
      if (done) begin
        ndone++;
        chk("ignore_done_cycle", 32'(k), 32'd34);
        chk("ignore_result", result, 32'd14);
        start = 1'b0;
      end
    end
    chk("ignore_done_count", 32'(ndone), 32'd1);

    // Flush mid-MUL: idle next cycle, no done, result unchanged.
    @(posedge clk); #1;
    funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin @(posedge clk); #1; end
    flush = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin @(posedge clk); #1; if (done) ndone++; end
    chk("flush_no_done", 32'(ndone), 32'd0);
    chk("flush_result", result, 32'd14);

    // Flush and start in the same idle cycle: request dropped.
    @(posedge clk); #1;
    funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-DIV.
    @(posedge clk); #1;
    funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin @(posedge clk); #1; end
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_ctrl", {30'd0, busy, done}, 32'd0);
    chk("async_reset_result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("post_reset_mul", 3'd0, 32'd3, 32'd4, 32'd12, 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
